ifetch: RTL and testbench

- Instruction fetch stage, directly downstream of pc_control.
- Owns the fetch PC and issues single-outstanding requests to instruction memory.
- Buffers returned instructions with their PCs in a small FIFO toward decode.
- Applies redirects (target/target_valide) and flushes from pc_control, discarding stale in-flight responses.

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/ifetch_fifo.sv | 61 ++++++
 rtl/ifetch.sv | 153 +++++++++++++++
 tb/tb_ifetch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch stage
package ifetch_pkg;

    localparam int ILEN = 32;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - synchronous instruction buffer between fetch and decode
// Flush clears pointers and count and overrides any same-cycle push or pop.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full buffer is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_COUNT) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - fetch PC owner, single-outstanding imem requester, buffered output to decode
// Optional build macro IFETCH_PERF_EN adds saturating fetched/killed counters.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int              xlen       = 32,
    parameter logic [xlen-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [xlen-1:0] target,
    input  logic            target_valide,
    input  logic            flush,
    output logic            imem_req,
    output logic [xlen-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [xlen-1:0] instr_pc,
    input  logic            instr_ready
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_killed
`endif
);

    localparam int              CW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [CW:0]     DEPTH_W    = (CW + 1)'(FIFO_DEPTH);
    localparam logic [xlen-1:0] ALIGN_MASK = ~xlen'(3);

    typedef struct packed {
        logic [xlen-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    fetch_state_t    state;
    logic [xlen-1:0] pc;
    logic [xlen-1:0] req_pc;
    logic            kill;

    logic            flush_now;
    logic            resp;
    logic            push;
    logic            pop;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     fill_after;
    entry_t          push_data;
    entry_t          head;

    assign flush_now = flush && target_valide;
    assign resp      = (state == WAIT) && imem_rvalid;
    // A response is only useful if nothing redirected the stream since it was granted.
    assign push      = resp && !kill && !target_valide;
    assign pop       = instr_valid && instr_ready;
    assign push_data = {req_pc, imem_rdata};
    assign fill_after = {1'b0, fifo_count} + {{CW{1'b0}}, push};

    assign imem_addr   = pc;
    assign instr_valid = (fifo_count != '0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC & ALIGN_MASK;
            req_pc   <= '0;
            kill     <= 1'b0;
            imem_req <= 1'b0;
        end else begin
            if (target_valide) begin
                pc <= target & ALIGN_MASK;
            end
            case (state)
                IDLE: begin
                    if (fifo_count < DEPTH_C) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        req_pc   <= pc;
                        state    <= WAIT;
                        imem_req <= 1'b0;
                        if (target_valide) begin
                            kill <= 1'b1;
                        end else begin
                            pc <= pc + xlen'(4);
                        end
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        kill <= 1'b0;
                        if (flush_now || (fill_after < DEPTH_W)) begin
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (target_valide) begin
                        kill <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    ifetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_now),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

`ifdef IFETCH_PERF_EN
    logic drop;

    assign drop = resp && (kill || target_valide);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_killed  <= '0;
        end else begin
            if (push && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (drop && (perf_killed != '1)) begin
                perf_killed <= perf_killed + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - randomized fetch-stage bench against a transaction-level expected-stream model
module tb_ifetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] SCRAMBLE = 32'hA5A5_A5A5;

    logic        clk           = 1'b0;
    logic        rst           = 1'b1;
    logic [31:0] target        = '0;
    logic        target_valide = 1'b0;
    logic        flush         = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt      = 1'b0;
    logic        imem_rvalid   = 1'b0;
    logic [31:0] imem_rdata    = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready   = 1'b0;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_killed;
`endif

    ifetch #(
        .xlen       (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .target        (target),
        .target_valide (target_valide),
        .flush         (flush),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_killed   (perf_killed)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    // Model: instructions still owed to decode, the next fetch address, and the
    // request the memory is currently serving (stale once any redirect touches it).
    exp_t        exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] exp_pc = RST_PC;
    bit          m_inflight = 1'b0;
    bit          m_stale    = 1'b0;
    logic [31:0] m_pc       = '0;
    bit          mem_pending = 1'b0;
    logic [31:0] mem_addr    = '0;
    logic [31:0] n_fetched   = '0;
    logic [31:0] n_killed    = '0;
    bit          s_req;
    bit          s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_pc;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input bit want_gnt, input bit want_rv, input bit rdy,
                         input bit redir, input bit fl, input logic [31:0] tgt);
        bit fln;
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = instr_valid;
        s_pc    = instr_pc;
        check_eq("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        if (instr_valid && exp_q.size() != 0) begin
            check_eq("instr_pc", instr_pc, exp_q[0].pc);
            check_eq("instr", instr, exp_q[0].word);
        end
        if (imem_req) begin
            check_eq("imem_addr", imem_addr, exp_pc);
            check_eq("req_space", 32'(exp_q.size() < DEPTH), 32'd1);
            check_eq("one_outstanding", 32'(m_inflight), 32'd0);
        end
`ifdef IFETCH_PERF_EN
        check_eq("perf_fetched", perf_fetched, n_fetched);
        check_eq("perf_killed", perf_killed, n_killed);
`endif
        imem_gnt      = want_gnt && imem_req && !mem_pending;
        imem_rvalid   = want_rv && mem_pending;
        imem_rdata    = imem_rvalid ? (mem_addr ^ SCRAMBLE) : $urandom;
        instr_ready   = rdy;
        target_valide = redir;
        flush         = fl;
        target        = tgt;
        fln = redir && fl;
        if (instr_valid && rdy && !fln) begin
            got_q.push_back(instr_pc);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (imem_rvalid) begin
            if (m_inflight) begin
                if (m_stale || redir) n_killed++;
                else begin
                    exp_q.push_back('{pc: m_pc, word: m_pc ^ SCRAMBLE});
                    n_fetched++;
                end
                m_inflight = 1'b0;
            end
            mem_pending = 1'b0;
        end else if (m_inflight && redir) begin
            m_stale = 1'b1;
        end
        if (imem_gnt) begin
            m_inflight  = 1'b1;
            m_stale     = redir;
            m_pc        = exp_pc;
            mem_pending = 1'b1;
            mem_addr    = imem_addr;
            exp_pc      = redir ? (tgt & ~32'd3) : exp_pc + 32'd4;
        end else if (redir) begin
            exp_pc = tgt & ~32'd3;
        end
        if (fln) exp_q.delete();
        @(posedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; target_valide = 1'b0; flush = 1'b0; instr_ready = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
`ifdef IFETCH_PERF_EN
        check_eq("rst_perf_fetched", perf_fetched, 32'd0);
        check_eq("rst_perf_killed", perf_killed, 32'd0);
`endif
        exp_q.delete();
        got_q.delete();
        exp_pc = RST_PC; m_inflight = 1'b0; m_stale = 1'b0; n_fetched = '0; n_killed = '0;
        rst = 1'b0;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] want_addr);
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            seen = s_req;
        end
        check_eq({tag, "_seen"}, 32'(seen), 32'd1);
        check_eq({tag, "_addr"}, s_addr, want_addr);
    endtask

    task automatic wait_inflight();
        for (int i = 0; i < 8 && !m_inflight; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_eq("reach_wait", 32'(m_inflight), 32'd1);
    endtask

    initial begin
        // streaming: consecutive words, each with its scrambled data
        do_reset(2);
        repeat (14) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        check_eq("stream_len", 32'(got_q.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < got_q.size(); i++) check_eq("stream_pc", got_q[i], 32'(4 * i));

        // fill with decode stalled, then resume after one dequeue
        do_reset(1);
        repeat (24) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check_eq("fill_req_low", 32'(s_req), 32'd0);
        check_eq("fill_head_pc", s_pc, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        wait_req("resume", 32'h10);

        // redirect while waiting: response dropped, buffered entries kept
        do_reset(1);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        wait_inflight();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
        wait_req("redir_wait", 32'h100);
        repeat (20) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        check_eq("redir_first", got_q.size() != 0 ? got_q[0] : 32'hFFFF_FFFF, 32'h0);

        // flush with three buffered entries and decode ready in the same cycle
        do_reset(1);
        for (int i = 0; i < 20 && exp_q.size() < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h203);
        got_q.delete();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        check_eq("flush_empty", 32'(s_valid), 32'd0);
        for (int i = 0; i < 12 && got_q.size() == 0; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        check_eq("flush_first", got_q.size() != 0 ? got_q[0] : 32'hFFFF_FFFF, 32'h200);

        // redirect coincident with the grant of 0x8
        do_reset(1);
        for (int i = 0; i < 12 && exp_pc != 32'h8; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40);
        wait_req("gnt_redir", 32'h40);

        // reset during an outstanding request; its late response must be ignored
        do_reset(1);
        wait_inflight();
        do_reset(1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check_eq("orphan_empty", 32'(instr_valid), 32'd0);
        wait_req("orphan", RST_PC);

        // randomized traffic, redirects, flushes and occasional resets
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] tgt;
            if ($urandom_range(0, 399) == 0) do_reset(1);
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFF8 | ($urandom & 32'h7);
                default: tgt = $urandom & 32'h0000_0FFF;
            endcase
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, tgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
